simon_seq_ctrl: RTL and testbench
=================================

Name: simon_seq_ctrl

Overview:
- Parametrised successor to the tile-game graphics control unit.
- Draws a board of NUM_TILES tiles, latches a difficulty, and fills an internal sequence memory from the external random source.
- Plays the stored sequence back as timed flash/restore draws, then checks player presses against it and reports win/lose.
- Sits between the key/LFSR inputs and the tile datapath (colour/coordinate loader plus VGA writer).

Parameters:
- NUM_TILES, 4: tiles on board; TW = max(1, clog2(NUM_TILES)).
- TILE_PIXELS, 64: pixels per tile draw; PW = clog2(TILE_PIXELS).
- MAX_SEQ, 16: sequence memory depth; SW = clog2(MAX_SEQ+1).
- LEN_EASY / LEN_NORMAL / LEN_HARD, 3/6/9: sequence lengths for levels 0/1/2. Each is clamped to MAX_SEQ. Level 3 selects MAX_SEQ.
- HOLD_CYCLES, 8: idle cycles a flashed tile stays lit before restore (≥1).
- GAP_CYCLES, 4: idle cycles between a restore and the next flash (≥1).

Ports:
- clock, in, 1: system clock.
- resetn, in, 1: synchronous, active-low reset.
- start_n, in, 1: active-low key. Starts the board draw from BOOT and a round from IDLE.
- level, in, 2: difficulty select, sampled in IDLE on start.
- rand_tile, in, TW: random tile index from the LFSR; values ≥ NUM_TILES are reduced mod NUM_TILES.
- press_valid, in, 1: one-cycle player press strobe.
- press_tile, in, TW: pressed tile index, valid with press_valid.
- ld_tile, out, 1: load base colour/coords for tile_num.
- ld_flash, out, 1: load flash colour/coords for tile_num.
- tile_num, out, TW: tile being loaded/drawn.
- write_en, out, 1: pixel write strobe.
- pixel_idx, out, PW: pixel offset within tile, valid with write_en.
- rand_en, out, 1: advance LFSR; rand_tile is captured in the same cycle.
- seq_len, out, SW: active sequence length.
- seq_idx, out, SW: current playback/check position.
- busy, out, 1: high in every state except BOOT and IDLE.
- win, out, 1: level, set on a full correct entry.
- lose, out, 1: level, set on the first wrong press.

Behaviour:
- Reset (resetn=0 at a clock edge, from any state, including mid-draw):
  - state goes to BOOT.
  - All strobes are 0; tile_num, pixel_idx, seq_idx, win and lose are 0.
  - seq_len = clamp(LEN_EASY); sequence memory contents are don't-care.
- Tile draw primitive (LOAD then DRAW):
  - LOAD asserts ld_tile or ld_flash for exactly 1 cycle with tile_num valid, and clears the pixel counter.
  - DRAW asserts write_en for exactly TILE_PIXELS consecutive cycles with pixel_idx = 0..TILE_PIXELS-1.
  - tile_num is stable from LOAD through the last DRAW cycle.
- BOOT: waits for start_n=0, then goes to INIT_LOAD.
- INIT_LOAD / INIT_DRAW: draw primitive with ld_tile for tiles 0..NUM_TILES-1 in order, then go to IDLE.
- IDLE:
  - On start_n=0: latch seq_len from level, clear win/lose, clear seq_idx, go to GEN.
  - The previous win/lose stays visible until that start.
- GEN: for k = 0..seq_len-1, one cycle each: rand_en=1 and mem[k] <= rand_tile. Exactly seq_len cycles, then go to PLAY_LOAD with seq_idx=0.
- Playback loop:
  - PLAY_LOAD (ld_flash, tile_num = mem[seq_idx]) -> PLAY_DRAW -> HOLD (HOLD_CYCLES cycles).
  - Then REST_LOAD (ld_tile, same tile) -> REST_DRAW -> GAP (GAP_CYCLES cycles).
  - At the end of GAP, seq_idx increments. If the new seq_idx == seq_len, clear seq_idx and go to INPUT; otherwise go to PLAY_LOAD.
- INPUT:
  - On press_valid, compare press_tile with mem[seq_idx].
  - Mismatch: lose=1, go to IDLE.
  - Match and seq_idx == seq_len-1: win=1, go to IDLE.
  - Match otherwise: seq_idx increments.
  - While waiting, tile feedback is not drawn.
- Presses outside INPUT are ignored and have no side effects. start_n is ignored while busy.
- The counter for seq_idx has a single driver, reset by resetn and by the round start; no other clock is used for it.
- Boundary: seq_len=1 gives one flash, then a single press decides the round. Consecutive identical tiles are each played with a full restore and gap.

Test Plan:
- Reset, then start_n pulse -> 4 ld_tile pulses for tiles 0,1,2,3; 256 write_en cycles, 64 per tile with pixel_idx 0..63; then IDLE with busy=0.
- level=1 start with rand_tile driven 2,0,3,1,1,2 -> seq_len=6 and exactly 6 rand_en cycles. Playback ld_flash tile order is 2,0,3,1,1,2. Each flash is followed after HOLD_CYCLES=8 idle cycles by ld_tile on the same tile, with a 4-cycle gap before the next flash.
- level=0, sequence 3,1,2, presses 3,1,2 -> win=1 after the third press, lose=0, back in IDLE.
- Same sequence, presses 3,2 -> lose=1 on the second press; further presses are ignored; win=0.
- resetn=0 during PLAY_DRAW at pixel_idx=30 -> next cycle write_en=0, state BOOT, seq_idx=0, seq_len=3.
- level=3 with MAX_SEQ=16 -> seq_len=16, 16 rand_en cycles, 16 flash/restore pairs; a press during playback has no effect.

Source files
------------

// File: rtl/simon_seq_ctrl.sv
// Sequence-game control unit: draws the board, fills a random sequence,
// plays it back as flash/restore draws and checks player presses against it.
module simon_seq_ctrl #(
  parameter int unsigned NUM_TILES   = 4,
  parameter int unsigned TILE_PIXELS = 64,
  parameter int unsigned MAX_SEQ     = 16,
  parameter int unsigned LEN_EASY    = 3,
  parameter int unsigned LEN_NORMAL  = 6,
  parameter int unsigned LEN_HARD    = 9,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  localparam int unsigned TW = (NUM_TILES > 2) ? $clog2(NUM_TILES) : 1,
  localparam int unsigned PW = (TILE_PIXELS > 2) ? $clog2(TILE_PIXELS) : 1,
  localparam int unsigned SW = $clog2(MAX_SEQ + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start_n,
  input  logic [1:0]    level,
  input  logic [TW-1:0] rand_tile,
  input  logic          press_valid,
  input  logic [TW-1:0] press_tile,
  output logic          ld_tile,
  output logic          ld_flash,
  output logic [TW-1:0] tile_num,
  output logic          write_en,
  output logic [PW-1:0] pixel_idx,
  output logic          rand_en,
  output logic [SW-1:0] seq_len,
  output logic [SW-1:0] seq_idx,
  output logic          busy,
  output logic          win,
  output logic          lose
);

  localparam int unsigned AW     = (MAX_SEQ > 2) ? $clog2(MAX_SEQ) : 1;
  localparam int unsigned WMAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned WW     = $clog2(WMAX + 1);
  localparam int unsigned L_EASY = (LEN_EASY   > MAX_SEQ) ? MAX_SEQ : LEN_EASY;
  localparam int unsigned L_NORM = (LEN_NORMAL > MAX_SEQ) ? MAX_SEQ : LEN_NORMAL;
  localparam int unsigned L_HARD = (LEN_HARD   > MAX_SEQ) ? MAX_SEQ : LEN_HARD;

  typedef enum logic [3:0] {
    BOOT, INIT_LOAD, INIT_DRAW, IDLE, GEN,
    PLAY_LOAD, PLAY_DRAW, HOLD, REST_LOAD, REST_DRAW, GAP, INPUT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tile_d;
  logic [PW-1:0] pix_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] idx_d, len_d;
  logic          win_d, lose_d;
  logic          mem_we;
  logic [TW-1:0] mem [MAX_SEQ];
  logic [TW-1:0] rand_mod, mem_cur, mem_nxt;
  logic [SW-1:0] level_len;
  logic          last_pix, last_idx;

  assign rand_mod = TW'(32'(rand_tile) % NUM_TILES);
  assign mem_cur  = mem[AW'(seq_idx)];
  assign mem_nxt  = mem[AW'(seq_idx + SW'(1))];
  assign last_pix = (pixel_idx == PW'(TILE_PIXELS - 1));
  assign last_idx = ((seq_idx + SW'(1)) == seq_len);

  always_comb begin
    case (level)
      2'd0:    level_len = SW'(L_EASY);
      2'd1:    level_len = SW'(L_NORM);
      2'd2:    level_len = SW'(L_HARD);
      default: level_len = SW'(MAX_SEQ);
    endcase
  end

  // Sequence memory: no reset, written only while generating.
  always_ff @(posedge clock) begin
    if (mem_we) mem[AW'(seq_idx)] <= rand_mod;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    tile_d  = tile_num;
    pix_d   = pixel_idx;
    wait_d  = wait_q;
    idx_d   = seq_idx;
    len_d   = seq_len;
    win_d   = win;
    lose_d  = lose;
    mem_we  = 1'b0;
    case (state_q)
      BOOT: begin
        if (!start_n) begin
          tile_d  = '0;
          state_d = INIT_LOAD;
        end
      end
      INIT_LOAD: begin
        pix_d   = '0;
        state_d = INIT_DRAW;
      end
      INIT_DRAW: begin
        pix_d = pixel_idx + PW'(1);
        if (last_pix) begin
          pix_d = '0;
          if (tile_num == TW'(NUM_TILES - 1)) begin
            state_d = IDLE;
          end else begin
            tile_d  = tile_num + TW'(1);
            state_d = INIT_LOAD;
          end
        end
      end
      IDLE: begin
        if (!start_n) begin
          len_d   = level_len;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          idx_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        mem_we = 1'b1;
        if (last_idx) begin
          idx_d   = '0;
          // mem[0] is still being written when the sequence has length 1
          tile_d  = (seq_idx == '0) ? rand_mod : mem[0];
          state_d = PLAY_LOAD;
        end else begin
          idx_d = seq_idx + SW'(1);
        end
      end
      PLAY_LOAD: begin
        pix_d   = '0;
        state_d = PLAY_DRAW;
      end
      PLAY_DRAW: begin
        pix_d = pixel_idx + PW'(1);
        if (last_pix) begin
          pix_d   = '0;
          wait_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        wait_d = wait_q + WW'(1);
        if (wait_q == WW'(HOLD_CYCLES - 1)) state_d = REST_LOAD;
      end
      REST_LOAD: begin
        pix_d   = '0;
        state_d = REST_DRAW;
      end
      REST_DRAW: begin
        pix_d = pixel_idx + PW'(1);
        if (last_pix) begin
          pix_d   = '0;
          wait_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        wait_d = wait_q + WW'(1);
        if (wait_q == WW'(GAP_CYCLES - 1)) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = INPUT;
          end else begin
            idx_d   = seq_idx + SW'(1);
            tile_d  = mem_nxt;
            state_d = PLAY_LOAD;
          end
        end
      end
      INPUT: begin
        if (press_valid) begin
          if (press_tile != mem_cur) begin
            lose_d  = 1'b1;
            state_d = IDLE;
          end else if (last_idx) begin
            win_d   = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = seq_idx + SW'(1);
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State register; strobes are registered from the next state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= BOOT;
      tile_num  <= '0;
      pixel_idx <= '0;
      wait_q    <= '0;
      seq_idx   <= '0;
      seq_len   <= SW'(L_EASY);
      win       <= 1'b0;
      lose      <= 1'b0;
      ld_tile   <= 1'b0;
      ld_flash  <= 1'b0;
      write_en  <= 1'b0;
      rand_en   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_num  <= tile_d;
      pixel_idx <= pix_d;
      wait_q    <= wait_d;
      seq_idx   <= idx_d;
      seq_len   <= len_d;
      win       <= win_d;
      lose      <= lose_d;
      ld_tile   <= (state_d == INIT_LOAD) || (state_d == REST_LOAD);
      ld_flash  <= (state_d == PLAY_LOAD);
      write_en  <= (state_d == INIT_DRAW) || (state_d == PLAY_DRAW) || (state_d == REST_DRAW);
      rand_en   <= (state_d == GEN);
      busy      <= (state_d != BOOT) && (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl: board draw, playback timing, win/lose and reset.
module tb_simon_seq_ctrl;

  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic       clock = 1'b0;
  logic       resetn, start_n, press_valid;
  logic [1:0] level, rand_tile, press_tile, tile_num;
  logic       ld_tile, ld_flash, write_en, rand_en, busy, win, lose;
  logic [5:0] pixel_idx;
  logic [4:0] seq_len, seq_idx;

  simon_seq_ctrl dut (
    .clock(clock), .resetn(resetn), .start_n(start_n), .level(level),
    .rand_tile(rand_tile), .press_valid(press_valid), .press_tile(press_tile),
    .ld_tile(ld_tile), .ld_flash(ld_flash), .tile_num(tile_num),
    .write_en(write_en), .pixel_idx(pixel_idx), .rand_en(rand_en),
    .seq_len(seq_len), .seq_idx(seq_idx), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int vals[16];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Event monitor sampled on the falling edge.
  logic mon_clr = 1'b0;
  int cyc = 0, ld_cnt = 0, fl_cnt = 0, we_cnt = 0, rd_cnt = 0;
  int pix_err = 0, tile_err = 0, hold_err = 0, gap_err = 0;
  int last_we = 0, pix_exp = 0, cur_tile = 0;
  bit after_flash = 1'b0, after_rest = 1'b0;
  int ld_tiles[$];
  int fl_tiles[$];

  always @(negedge clock) begin
    cyc++;
    if (mon_clr) begin
      ld_cnt = 0; fl_cnt = 0; we_cnt = 0; rd_cnt = 0;
      pix_err = 0; tile_err = 0; hold_err = 0; gap_err = 0;
      pix_exp = 0; after_flash = 1'b0; after_rest = 1'b0;
      ld_tiles.delete();
      fl_tiles.delete();
    end else begin
      if (ld_tile) begin
        ld_cnt++;
        ld_tiles.push_back(int'(tile_num));
        if (after_flash && (cyc - last_we - 1) != HOLD) hold_err++;
        after_rest  = after_flash;
        after_flash = 1'b0;
        pix_exp     = 0;
        cur_tile    = int'(tile_num);
      end
      if (ld_flash) begin
        fl_cnt++;
        fl_tiles.push_back(int'(tile_num));
        if (after_rest && (cyc - last_we - 1) != GAP) gap_err++;
        after_flash = 1'b1;
        after_rest  = 1'b0;
        pix_exp     = 0;
        cur_tile    = int'(tile_num);
      end
      if (write_en) begin
        we_cnt++;
        if (int'(pixel_idx) != pix_exp) pix_err++;
        if (int'(tile_num) != cur_tile) tile_err++;
        pix_exp++;
        last_we = cyc;
      end
      if (rand_en) rd_cnt++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start_n = 1'b0;
    tick();
    start_n = 1'b1;
  endtask

  task automatic gen_feed(input int n);
    check("gen_rand_en", int'(rand_en), 1);
    for (int k = 0; k < n; k++) begin
      rand_tile = 2'(vals[k]);
      tick();
    end
    check("gen_rand_cnt", rd_cnt, n);
    check("gen_rand_en_off", int'(rand_en), 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy && t < budget) begin tick(); t++; end
    check(tag, int'(busy), 0);
  endtask

  task automatic wait_input(input int n);
    int t = 0;
    while (ld_cnt < n && t < 5000) begin tick(); t++; end
    check("input_reached", int'(ld_cnt >= n), 1);
    repeat (72) tick();
  endtask

  task automatic press(input int t);
    press_tile  = 2'(t);
    press_valid = 1'b1;
    tick();
    press_valid = 1'b0;
  endtask

  task automatic check_playback(input int n);
    check("flash_cnt", fl_cnt, n);
    check("restore_cnt", ld_cnt, n);
    for (int i = 0; i < n; i++) begin
      check("flash_tile", (i < fl_tiles.size()) ? fl_tiles[i] : -1, vals[i]);
      check("restore_tile", (i < ld_tiles.size()) ? ld_tiles[i] : -1, vals[i]);
    end
    check("hold_timing", hold_err, 0);
    check("gap_timing", gap_err, 0);
    check("play_pixels", pix_err, 0);
    check("play_tile_stable", tile_err, 0);
    check("play_we_cnt", we_cnt, 2 * 64 * n);
  endtask

  initial begin
    int t;
    resetn = 1'b0; start_n = 1'b1; press_valid = 1'b0;
    press_tile = '0; level = '0; rand_tile = '0;
    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_write_en", int'(write_en), 0);
    check("rst_ld_tile", int'(ld_tile), 0);
    check("rst_ld_flash", int'(ld_flash), 0);
    check("rst_rand_en", int'(rand_en), 0);
    check("rst_tile_num", int'(tile_num), 0);
    check("rst_pixel_idx", int'(pixel_idx), 0);
    check("rst_seq_idx", int'(seq_idx), 0);
    check("rst_seq_len", int'(seq_len), 3);
    check("rst_win", int'(win), 0);
    check("rst_lose", int'(lose), 0);
    resetn = 1'b1;
    repeat (3) tick();
    check("boot_waits", int'(busy), 0);

    // Board draw
    clr_mon();
    pulse_start();
    check("boot_busy", int'(busy), 1);
    wait_idle("boot_idle", 600);
    check("boot_ld_cnt", ld_cnt, 4);
    for (int i = 0; i < 4; i++) check("boot_tile", (i < ld_tiles.size()) ? ld_tiles[i] : -1, i);
    check("boot_we_cnt", we_cnt, 256);
    check("boot_pixels", pix_err, 0);
    check("boot_tile_stable", tile_err, 0);
    check("boot_no_flash", fl_cnt, 0);

    // Level 1 playback order and timing, then a wrong first press
    level = 2'd1;
    vals = '{2, 0, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    clr_mon();
    pulse_start();
    check("l1_seq_len", int'(seq_len), 6);
    gen_feed(6);
    wait_input(6);
    check_playback(6);
    check("l1_input_idx", int'(seq_idx), 0);
    check("l1_input_busy", int'(busy), 1);
    press(0);
    check("l1_lose", int'(lose), 1);
    check("l1_idle", int'(busy), 0);

    // Level 0 win
    level = 2'd0;
    vals = '{3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    clr_mon();
    pulse_start();
    check("win_lose_cleared", int'(lose), 0);
    check("win_seq_len", int'(seq_len), 3);
    gen_feed(3);
    wait_input(3);
    check_playback(3);
    press(3);
    check("win_idx1", int'(seq_idx), 1);
    check("win_not_yet", int'(win), 0);
    press(1);
    check("win_idx2", int'(seq_idx), 2);
    press(2);
    check("win_set", int'(win), 1);
    check("win_no_lose", int'(lose), 0);
    check("win_idle", int'(busy), 0);
    press(0);
    repeat (3) tick();
    check("win_persists", int'(win), 1);
    check("win_idle_press", int'(lose), 0);

    // Same sequence, wrong second press
    clr_mon();
    pulse_start();
    check("lose_win_cleared", int'(win), 0);
    gen_feed(3);
    wait_input(3);
    press(3);
    check("lose_not_yet", int'(lose), 0);
    press(2);
    check("lose_set", int'(lose), 1);
    check("lose_idle", int'(busy), 0);
    press(1);
    press(2);
    check("lose_after_ignored", int'(lose), 1);
    check("lose_no_win", int'(win), 0);
    check("lose_still_idle", int'(busy), 0);

    // Reset in the middle of a flash draw
    level = 2'd2;
    vals = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    clr_mon();
    pulse_start();
    check("l2_seq_len", int'(seq_len), 9);
    gen_feed(9);
    t = 0;
    while (!(write_en && pixel_idx == 6'd30 && fl_cnt >= 2) && t < 400) begin tick(); t++; end
    check("mid_draw_found", int'(t < 400), 1);
    check("mid_draw_idx", int'(seq_idx), 1);
    resetn = 1'b0;
    tick();
    check("mrst_write_en", int'(write_en), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_seq_idx", int'(seq_idx), 0);
    check("mrst_seq_len", int'(seq_len), 3);
    check("mrst_pixel_idx", int'(pixel_idx), 0);
    resetn = 1'b1;
    tick();
    clr_mon();
    pulse_start();
    wait_idle("reboot_idle", 600);
    check("reboot_ld_cnt", ld_cnt, 4);
    check("reboot_we_cnt", we_cnt, 256);

    // Level 3: full-depth sequence, press during playback ignored
    level = 2'd3;
    vals = '{1, 3, 0, 2, 2, 1, 0, 3, 3, 0, 1, 2, 0, 0, 3, 1};
    clr_mon();
    pulse_start();
    check("l3_seq_len", int'(seq_len), 16);
    gen_feed(16);
    t = 0;
    while (fl_cnt < 3 && t < 1000) begin tick(); t++; end
    check("l3_third_flash", int'(fl_cnt >= 3), 1);
    press(1);
    check("l3_play_idx", int'(seq_idx), 2);
    check("l3_play_lose", int'(lose), 0);
    check("l3_play_busy", int'(busy), 1);
    wait_input(16);
    check_playback(16);
    check("l3_input_idx", int'(seq_idx), 0);
    for (int i = 0; i < 16; i++) press(vals[i]);
    check("l3_win", int'(win), 1);
    check("l3_lose", int'(lose), 0);
    check("l3_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
